// File: rtl/remove_cp.sv
// Cyclic-prefix removal for the 802.16 OFDM receive chain: consumes 320-sample
// symbols and forwards the 256 useful samples. Optional macro: CP_ADV_EN.
module remove_cp #(
  parameter int N_FFT = 256,
  parameter int N_CP  = 64,
  parameter int ADV   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [31:0] dat_in,
  output logic        ack_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  input  logic        ack_i,
  output logic [31:0] dat_out,
  output logic        sym_start
);

  localparam int SYM_LEN = N_FFT + N_CP;
  localparam int IDX_W   = $clog2(SYM_LEN);

  // With CP_ADV_EN the window starts ADV samples inside the prefix so that a
  // slightly late timing estimate still lands the FFT window inside the symbol.
`ifdef CP_ADV_EN
  localparam int SHIFT = ADV;
`else
  localparam int SHIFT = ADV * 0;
`endif

  localparam logic [IDX_W-1:0] WIN_LO   = IDX_W'(N_CP - SHIFT);
  localparam logic [IDX_W-1:0] WIN_HI   = IDX_W'(SYM_LEN - 1 - SHIFT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SYM_LEN - 1);

  logic [IDX_W-1:0] idx;
  logic             out_halt;
  logic             accept;
  logic             in_window;
  logic             fwd;

  assign out_halt  = stb_o & ~ack_i;
  assign accept    = cyc_i & stb_i & ~out_halt;
  assign ack_o     = accept;
  assign we_o      = stb_o;
  assign in_window = (idx >= WIN_LO) && (idx <= WIN_HI);
  assign fwd       = accept & in_window;

  // Position within the current symbol; every new burst restarts at a CP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (!cyc_i) begin
      idx <= '0;
    end else if (accept) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stb_o     <= 1'b0;
      sym_start <= 1'b0;
      dat_out   <= '0;
    end else if (!out_halt) begin
      stb_o     <= fwd;
      sym_start <= fwd && (idx == WIN_LO);
      if (fwd) begin
        dat_out <= dat_in;
      end
    end
  end

  // The burst stays open downstream until the last forwarded sample is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_o <= 1'b0;
    end else if (fwd) begin
      cyc_o <= 1'b1;
    end else if (!cyc_i && !out_halt) begin
      cyc_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_remove_cp.sv
// Scoreboard bench for remove_cp: expected forwarded samples are queued when
// the DUT accepts them and checked when the downstream side takes them.
module tb_remove_cp;

  localparam int N_FFT = 256;
  localparam int N_CP  = 64;
  localparam int ADV   = 4;
  localparam int SYM   = N_FFT + N_CP;
`ifdef CP_ADV_EN
  localparam int LO = N_CP - ADV;
`else
  localparam int LO = N_CP;
`endif
  localparam int HI = LO + N_FFT - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic [31:0] dat_in = '0;
  logic        ack_i = 1'b0;
  logic        ack_o, cyc_o, stb_o, we_o, sym_start;
  logic [31:0] dat_out;

  typedef struct {
    logic [31:0] dat;
    logic        sym;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_idx = 0;
  int          sym_seen = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic        hold_s;
  logic        tog = 1'b0;

  remove_cp #(.N_FFT(N_FFT), .N_CP(N_CP), .ADV(ADV)) dut (
    .clk(clk), .rst(rst), .cyc_i(cyc_i), .stb_i(stb_i), .dat_in(dat_in),
    .ack_o(ack_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .ack_i(ack_i),
    .dat_out(dat_out), .sym_start(sym_start)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs after the edge, scoreboard the registered outputs,
  // and predict what the next edge will forward.
  task automatic drive(input logic c, input logic s, input logic [31:0] d,
                       input logic a, output logic acc, output logic halted);
    exp_t e;
    @(posedge clk);
    #1;
    cyc_i = c; stb_i = s; dat_in = d; ack_i = a;
    #1;
    if (hold_v) begin
      n_cmp++;
      if (stb_o !== 1'b1 || dat_out !== hold_d || sym_start !== hold_s)
        $display("[TB] FAIL hold: got stb=%b dat=%h sym=%b want stb=1 dat=%h sym=%b",
                 stb_o, dat_out, sym_start, hold_d, hold_s);
      if (stb_o !== 1'b1 || dat_out !== hold_d || sym_start !== hold_s) n_err++;
    end
    n_cmp++;
    if (we_o !== stb_o) begin
      n_err++;
      $display("[TB] FAIL we_o: got %b want %b", we_o, stb_o);
    end
    if (stb_o === 1'b1) begin
      n_cmp++;
      if (cyc_o !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL cyc_o_with_stb: got %b want 1", cyc_o);
      end
    end
    if (stb_o === 1'b1 && a === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("[TB] FAIL extra_output: got dat=%h want none", dat_out);
      end else begin
        e = sb.pop_front();
        if ({dat_out, sym_start} !== {e.dat, e.sym}) begin
          n_err++;
          $display("[TB] FAIL output: got dat=%h sym=%b want dat=%h sym=%b",
                   dat_out, sym_start, e.dat, e.sym);
        end
        if (sym_start === 1'b1) sym_seen++;
      end
    end
    hold_v = (stb_o === 1'b1) && (a === 1'b0);
    hold_d = dat_out;
    hold_s = sym_start;
    halted = (stb_o === 1'b1) && (a === 1'b0);
    acc = ack_o;
    if (!c) begin
      m_idx = 0;
    end else if (acc === 1'b1) begin
      if (m_idx >= LO && m_idx <= HI) sb.push_back('{dat: d, sym: (m_idx == LO)});
      m_idx = (m_idx == SYM - 1) ? 0 : m_idx + 1;
    end
  endtask

  task automatic send(input int n, input logic [31:0] base);
    logic acc, h;
    for (int i = 0; i < n; i++) begin
      int tries = 0;
      do begin
        drive(1'b1, 1'b1, base + 32'(i), 1'b1, acc, h);
        tries++;
      end while (acc !== 1'b1 && tries < 4);
      if (acc !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL accept_timeout: got ack_o=%b want 1", acc);
      end
    end
  endtask

  task automatic drain();
    logic acc, h;
    int   cycles = 0;
    do begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, acc, h);
      cycles++;
    end while ((sb.size() != 0 || stb_o === 1'b1) && cycles < 20);
    drive(1'b0, 1'b0, 32'h0, 1'b1, acc, h);
    n_cmp++;
    if (sb.size() != 0 || cyc_o !== 1'b0 || stb_o !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL drain: got pending=%0d cyc_o=%b stb_o=%b want 0/0/0",
               sb.size(), cyc_o, stb_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({stb_o, cyc_o, sym_start, we_o, ack_o, dat_out} !== 37'h0) begin
      n_err++;
      $display("[TB] FAIL reset_state: got stb=%b cyc=%b sym=%b we=%b ack=%b dat=%h want all 0",
               stb_o, cyc_o, sym_start, we_o, ack_o, dat_out);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_nominal();
    $display("[TB] nominal burst of 640");
    sym_seen = 0;
    send(10, 32'd0);
    n_cmp++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL cyc_o_in_cp: got cyc=%b stb=%b want 0/0", cyc_o, stb_o);
    end
    send(630, 32'd10);
    n_cmp++;
    if (cyc_o !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL cyc_o_burst: got %b want 1", cyc_o);
    end
    drain();
    n_cmp++;
    if (sym_seen != 2) begin
      n_err++;
      $display("[TB] FAIL nominal_sym_count: got %0d want 2", sym_seen);
    end
  endtask

  task automatic test_backpressure();
    logic acc, h;
    $display("[TB] backpressure, ack_i toggling");
    sym_seen = 0;
    for (int i = 0; i < 640; i++) begin
      int tries = 0;
      do begin
        tog = ~tog;
        drive(1'b1, 1'b1, 32'h0001_0000 + 32'(i), tog, acc, h);
        tries++;
        if (h) begin
          n_cmp++;
          if (acc !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL ack_while_halted: got %b want 0", acc);
          end
        end
      end while (acc !== 1'b1 && tries < 4);
      if (acc !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL bp_accept_timeout: got ack_o=%b want 1", acc);
      end
    end
    // Close the burst while the final sample is stalled downstream.
    repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0, acc, h);
    n_cmp++;
    if (cyc_o !== 1'b1 || stb_o !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL cyc_fall_halted: got cyc=%b stb=%b want 1/1", cyc_o, stb_o);
    end
    drain();
    n_cmp++;
    if (sym_seen != 2) begin
      n_err++;
      $display("[TB] FAIL bp_sym_count: got %0d want 2", sym_seen);
    end
  endtask

  task automatic test_cut();
    $display("[TB] mid-symbol cut then fresh burst");
    sym_seen = 0;
    send(100, 32'd0);
    drain();
    send(320, 32'hDEAD_0000);
    drain();
    n_cmp++;
    if (sym_seen != 2) begin
      n_err++;
      $display("[TB] FAIL cut_sym_count: got %0d want 2", sym_seen);
    end
  endtask

  task automatic test_reset_mid();
    $display("[TB] reset mid-symbol");
    send(150, 32'd0);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({stb_o, cyc_o, sym_start, we_o, dat_out} !== 36'h0) begin
      n_err++;
      $display("[TB] FAIL reset_mid: got stb=%b cyc=%b sym=%b we=%b dat=%h want all 0",
               stb_o, cyc_o, sym_start, we_o, dat_out);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    sb.delete();
    m_idx = 0;
    hold_v = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sym_seen = 0;
    send(320, 32'h0000_5000);
    drain();
    n_cmp++;
    if (sym_seen != 1) begin
      n_err++;
      $display("[TB] FAIL reset_mid_sym_count: got %0d want 1", sym_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, h;
    int   sent = 0;
    int   guard = 0;
    $display("[TB] three symbols back to back with stb_i gaps");
    sym_seen = 0;
    while (sent < 3 * SYM && guard < 5000) begin
      logic s;
      s = ($urandom_range(0, 3) != 0);
      drive(1'b1, s, 32'hC000_0000 + 32'(sent), 1'(($urandom_range(0, 4) != 0)), acc, h);
      if (acc === 1'b1) sent++;
      guard++;
    end
    n_cmp++;
    if (sent != 3 * SYM) begin
      n_err++;
      $display("[TB] FAIL b2b_timeout: got %0d samples want %0d", sent, 3 * SYM);
    end
    drain();
    n_cmp++;
    if (sym_seen != 3) begin
      n_err++;
      $display("[TB] FAIL b2b_sym_count: got %0d want 3", sym_seen);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_cut();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
